// File: rtl/pulse_period_monitor.sv
// ---------------------------------------------------------------------------
// pulse_period_monitor
//   Receive-side checker for a periodic single-cycle tick. It measures the
//   interval between successive pulses and declares lock after LOCK_CNT
//   consecutive in-tolerance intervals. Once locked, it flags early and
//   missing pulses, keeps a sticky error and a saturating error count, and
//   exposes the last measured interval.
//
// Ports
//   clk      : single clock, all logic on posedge
//   rst      : asynchronous, active-low reset
//   sig      : pulse under test, sampled on posedge clk
//   clr      : synchronous clear of err / err_cnt (an error on the same edge wins)
//   locked   : high while the monitor is in LOCKED
//   early    : one-cycle pulse, early pulse seen while LOCKED
//   miss     : one-cycle pulse, overdue pulse seen while LOCKED
//   err      : sticky error flag
//   period   : last measured interval (updated on pulses in ACQ / LOCKED)
//   err_cnt  : saturating count of early + missing pulses while LOCKED
// ---------------------------------------------------------------------------
module pulse_period_monitor #(
  parameter int unsigned PERIOD   = 751,
  parameter int unsigned TOL      = 0,
  parameter int unsigned CBITS    = 10,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  input  logic             clr,
  output logic             locked,
  output logic             early,
  output logic             miss,
  output logic             err,
  output logic [CBITS-1:0] period,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  localparam logic [CBITS-1:0] WIN_LO = CBITS'(PERIOD - TOL);
  localparam logic [CBITS-1:0] WIN_HI = CBITS'(PERIOD + TOL);
  localparam logic [3:0]       LOCK_N = 4'(LOCK_CNT);

  state_e           state_q, state_d;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [3:0]       good_q, good_d;

  logic             locked_q, locked_d;
  logic             early_q, early_d;
  logic             miss_q, miss_d;
  logic             err_q, err_d;
  logic [CBITS-1:0] period_q, period_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  // Classification of the interval that ends on this edge (pre-update cnt).
  logic iv_good, iv_early, timeout;
  logic early_ev, miss_ev, load_period;

  assign iv_early = (cnt_q < WIN_LO);
  assign iv_good  = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
  // First edge at which a pulse is overdue.
  assign timeout  = !sig && (cnt_q == WIN_HI);

  // Interval counter: restarts at 1 on a pulse, otherwise counts and saturates.
  always_comb begin
    if (sig)                cnt_d = CBITS'(1);
    else if (&cnt_q)        cnt_d = cnt_q;
    else                    cnt_d = cnt_q + CBITS'(1);
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d     = state_q;
    good_d      = good_q;
    early_ev    = 1'b0;
    miss_ev     = 1'b0;
    load_period = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // The first pulse only establishes a reference.
        if (sig) begin
          state_d = S_ACQ;
          good_d  = '0;
        end
      end
      S_ACQ: begin
        if (sig) begin
          load_period = 1'b1;
          if (iv_good) begin
            if (good_q + 4'd1 == LOCK_N) begin
              state_d = S_LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + 4'd1;
            end
          end else if (iv_early) begin
            good_d = '0;  // restart acquisition from this pulse
          end
        end else if (timeout) begin
          state_d = S_IDLE;
          good_d  = '0;
        end
      end
      S_LOCKED: begin
        if (sig) begin
          load_period = 1'b1;
          if (iv_early) begin
            early_ev = 1'b1;
            state_d  = S_ACQ;  // this pulse becomes the new reference
            good_d   = '0;
          end
        end else if (timeout) begin
          miss_ev = 1'b1;
          state_d = S_IDLE;
          good_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        good_d  = '0;
      end
    endcase
  end

  // Output logic (registered below).
  always_comb begin
    locked_d  = (state_d == S_LOCKED);
    early_d   = early_ev;
    miss_d    = miss_ev;
    period_d  = load_period ? cnt_q : period_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (clr) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end
    // An error on the same edge as clr wins: the count restarts at 1.
    if (early_ev || miss_ev) begin
      err_d = 1'b1;
      if (clr)                err_cnt_d = 8'd1;
      else if (&err_cnt_q)    err_cnt_d = err_cnt_q;
      else                    err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      good_q    <= '0;
      locked_q  <= 1'b0;
      early_q   <= 1'b0;
      miss_q    <= 1'b0;
      err_q     <= 1'b0;
      period_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      good_q    <= good_d;
      locked_q  <= locked_d;
      early_q   <= early_d;
      miss_q    <= miss_d;
      err_q     <= err_d;
      period_q  <= period_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign locked  = locked_q;
  assign early   = early_q;
  assign miss    = miss_q;
  assign err     = err_q;
  assign period  = period_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// ---------------------------------------------------------------------------
// tb_pulse_period_monitor
//   Three monitor instances share clk/rst:
//     0 : PERIOD=751 TOL=0 LOCK_CNT=4 (lock, early, miss, async reset)
//     1 : PERIOD=751 TOL=2 LOCK_CNT=4 (tolerance window)
//     2 : PERIOD=8   TOL=0 LOCK_CNT=1 (error-count saturation, clr)
//   Stimulus pushes expected events (lock rise, early, miss) into a queue; a
//   monitor on the falling edge pops and compares whenever an instance shows
//   one, so an unexpected or extra-long early/miss is also caught.
// ---------------------------------------------------------------------------
module tb_pulse_period_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] sig, clr;
  logic [2:0] locked, early, miss, err;
  logic [9:0] period [3];
  logic [7:0] err_cnt [3];

  pulse_period_monitor #(.PERIOD(751), .TOL(0), .CBITS(10), .LOCK_CNT(4)) u_dut_a (
    .clk(clk), .rst(rst), .sig(sig[0]), .clr(clr[0]),
    .locked(locked[0]), .early(early[0]), .miss(miss[0]), .err(err[0]),
    .period(period[0]), .err_cnt(err_cnt[0]));

  pulse_period_monitor #(.PERIOD(751), .TOL(2), .CBITS(10), .LOCK_CNT(4)) u_dut_b (
    .clk(clk), .rst(rst), .sig(sig[1]), .clr(clr[1]),
    .locked(locked[1]), .early(early[1]), .miss(miss[1]), .err(err[1]),
    .period(period[1]), .err_cnt(err_cnt[1]));

  pulse_period_monitor #(.PERIOD(8), .TOL(0), .CBITS(10), .LOCK_CNT(1)) u_dut_c (
    .clk(clk), .rst(rst), .sig(sig[2]), .clr(clr[2]),
    .locked(locked[2]), .early(early[2]), .miss(miss[2]), .err(err[2]),
    .period(period[2]), .err_cnt(err_cnt[2]));

  typedef struct packed {
    logic [1:0] dut;
    logic [1:0] kind;   // 0 lock rise, 1 early, 2 miss
    logic       lck;
    logic [9:0] per;
    logic       er;
    logic [7:0] ec;
  } ev_t;

  ev_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  err_m [3];
  int  cnt_m [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected error flag/count follow a tiny model: each early/miss sets err
  // and bumps the count up to 255.
  task automatic push_ev(input int d, input int kind, input int per);
    ev_t e;
    if (kind != 0) begin
      err_m[d] = 1;
      if (cnt_m[d] < 255) cnt_m[d]++;
    end
    e.dut  = 2'(d);
    e.kind = 2'(kind);
    e.lck  = (kind == 0);
    e.per  = 10'(per);
    e.er   = err_m[d][0];
    e.ec   = 8'(cnt_m[d]);
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse that closes an interval of n cycles since the previous pulse.
  task automatic send(input int d, input int n);
    sig[d] = 1'b0;
    repeat (n - 1) tick();
    sig[d] = 1'b1;
    tick();
    sig[d] = 1'b0;
  endtask

  task automatic hold(input int d, input int n);
    sig[d] = 1'b0;
    repeat (n) tick();
  endtask

  // Monitor: any early/miss cycle or locked rise is an event to be matched.
  logic [2:0] locked_prev = '0;
  ev_t        mon_act, mon_exp;
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (early[d] || miss[d] || (locked[d] && !locked_prev[d])) begin
        mon_act.dut  = 2'(d);
        mon_act.kind = early[d] ? 2'd1 : (miss[d] ? 2'd2 : 2'd0);
        mon_act.lck  = locked[d];
        mon_act.per  = period[d];
        mon_act.er   = err[d];
        mon_act.ec   = err_cnt[d];
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got event 0x%0h expected none", mon_act);
        end else begin
          mon_exp = sb_q.pop_front();
          check("sb_event", 32'(mon_act), 32'(mon_exp));
        end
      end
      locked_prev[d] = locked[d];
    end
  end

  initial begin
    rst = 1'b0;
    sig = '0;
    clr = '0;
    for (int d = 0; d < 3; d++) begin
      err_m[d] = 0;
      cnt_m[d] = 0;
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_outputs", {locked[d], early[d], miss[d], err[d], period[d], err_cnt[d]}, 0);
    end
    repeat (3) tick();
    rst = 1'b1;

    // Reference pulse from IDLE leaves period untouched; ACQ timeout is silent.
    send(0, 3);
    check("t1_no_period", 32'(period[0]), 0);
    hold(0, 800);
    check("t1_acq_timeout", {locked[0], err[0], err_cnt[0], period[0]}, 0);

    // Lock after 1 reference + 4 good intervals.
    repeat (4) send(0, 751);
    check("t2_not_locked_yet", 32'(locked[0]), 0);
    push_ev(0, 0, 751);
    send(0, 751);
    check("t2_locked", 32'(locked[0]), 1);
    check("t2_period", 32'(period[0]), 751);
    check("t2_no_err", {err[0], err_cnt[0]}, 0);

    // Early pulse, then re-lock from it as the new reference.
    push_ev(0, 1, 750);
    send(0, 750);
    check("t3_early", {early[0], locked[0], err[0], err_cnt[0]}, {1'b1, 1'b0, 1'b1, 8'd1});
    repeat (3) send(0, 751);
    check("t3_not_locked_yet", 32'(locked[0]), 0);
    push_ev(0, 0, 751);
    send(0, 751);

    // Missing pulse fires exactly at the edge where cnt reaches 751.
    hold(0, 750);
    check("t4_no_miss_yet", {miss[0], locked[0]}, 2'b01);
    push_ev(0, 2, 751);
    tick();
    check("t4_miss", {miss[0], locked[0], err_cnt[0]}, {1'b1, 1'b0, 8'd2});
    send(0, 20);
    repeat (3) send(0, 751);
    check("t4_not_locked_yet", 32'(locked[0]), 0);
    push_ev(0, 0, 751);
    send(0, 751);

    // Async reset mid-cycle clears outputs without a clock edge.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_async", {locked[0], early[0], miss[0], err[0], period[0], err_cnt[0]}, 0);
    #3;
    rst = 1'b1;
    err_m[0] = 0;
    cnt_m[0] = 0;
    tick();

    // Tolerance window [749, 753].
    send(1, 5);
    send(1, 100);
    check("t5_acq_early_period", {locked[1], err[1], period[1]}, {1'b0, 1'b0, 10'd100});
    send(1, 749);
    send(1, 753);
    send(1, 751);
    check("t5_not_locked_yet", 32'(locked[1]), 0);
    push_ev(1, 0, 750);
    send(1, 750);
    push_ev(1, 1, 748);
    send(1, 748);
    repeat (3) send(1, 751);
    push_ev(1, 0, 751);
    send(1, 751);
    hold(1, 752);
    check("t5_no_miss_yet", {miss[1], locked[1]}, 2'b01);
    push_ev(1, 2, 751);
    tick();
    check("t5_miss", {miss[1], err_cnt[1]}, {1'b1, 8'd2});

    // Saturation at 255, clr versus a simultaneous error, clr alone.
    send(2, 3);
    for (int i = 0; i < 256; i++) begin
      push_ev(2, 0, 8);
      send(2, 8);
      push_ev(2, 1, 1);
      send(2, 1);
    end
    check("t6_saturated", {err[2], err_cnt[2]}, {1'b1, 8'd255});
    push_ev(2, 0, 8);
    send(2, 8);
    cnt_m[2] = 0;
    push_ev(2, 1, 1);
    sig[2] = 1'b1;
    clr[2] = 1'b1;
    tick();
    sig[2] = 1'b0;
    clr[2] = 1'b0;
    check("t6_clr_vs_err", {err[2], err_cnt[2]}, {1'b1, 8'd1});
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    check("t6_clr_alone", {err[2], err_cnt[2]}, 0);
    err_m[2] = 0;
    cnt_m[2] = 0;
    hold(2, 20);
    check("t6_acq_timeout_silent", {locked[2], err[2], err_cnt[2]}, 0);

    repeat (3) tick();
    check("sb_drained", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
